adc_tag_framer: RTL and testbench
=================================

ADC_TAG_FRAMER -- requirements
Module: adc_tag_framer

Interface
REQ-001 Parameter TAG_TYPE_TIME, default 7'h01, tag_type value driven on every timestamp tag word.
REQ-002 Parameter LEN_W, default 16, width of packet-length register and sample-in-packet counter.
REQ-003 Ports (name  direction  width  meaning):
- user_clk  in  1  sole clock; all ports, including up_*, are synchronous to it.
- user_resetn  in  1  reset, asynchronous, active-low.
- up_wreq / up_waddr / up_wdata  in  1/9/32  register write request, address, data.
- up_wack  out  1  write acknowledge.
- up_rreq / up_raddr  in  1/9  register read request, address.
- up_rdata / up_rack  out  32/1  read data, read acknowledge.
- pps  in  1  pulse-per-second, already synchronous to user_clk.
- s_adc_valid / s_adc_data  in  1/64  sample stream in.
- s_adc_ready  out  1  sample stream accept.
- m_adc_ready  in  1  downstream accept.
- m_adc_valid / m_adc_data  out  1/64  framed stream out.
- m_adc_tag_valid / m_adc_tag_type / m_adc_last  out  1/7/1  word is a tag / tag type / final sample of packet.

Function
REQ-004 Registers (word address on up_*addr): 0x000 CTRL rw (bit0 enable, bit1 clear-timestamp, self-clearing, reads 0); 0x001 PKT_LEN rw [LEN_W-1:0]; 0x002/0x003 TIME_LO/HI ro, live timestamp; 0x004/0x005 PPS_LO/HI ro, timestamp captured at last pps rising edge; 0x006 PKT_CNT ro, 32-bit count of completed packets, wraps.
REQ-005 up_wack asserts for exactly one cycle, one cycle after up_wreq; up_rack asserts for one cycle, one cycle after up_rreq, with up_rdata valid that cycle; up_rdata is 0 whenever up_rack is 0; unmapped reads return 0 and are still acknowledged.
REQ-006 Timestamp: 64-bit counter, +1 on each accepted input sample (s_adc_valid & s_adc_ready), wraps at 2^64.
REQ-007 Clear-timestamp write sets the counter to 0 the following cycle; clear wins over a coincident increment.
REQ-008 pps rising edge (registered compare) copies the timestamp into PPS_LO/HI; TIME_HI and PPS_HI are not separately latched against the LO read.
REQ-009 FSM states IDLE, TAG, DATA.
- IDLE: s_adc_ready=0, no output; enable=1 -> TAG.
- TAG: present one word, m_adc_tag_valid=1, m_adc_tag_type=TAG_TYPE_TIME, m_adc_data=timestamp of the next sample, m_adc_last=0.
- DATA: pass samples with tag_valid=0.
REQ-010 PKT_LEN is latched on TAG entry; value 0 is treated as 1; register changes mid-packet affect only the next packet.
REQ-011 Output register: m_adc_* are registered and hold stable while m_adc_valid=1 and m_adc_ready=0; s_adc_ready = (state==DATA) & (~m_adc_valid | m_adc_ready); full throughput of one sample per cycle with m_adc_ready held high.
REQ-012 TAG->DATA when the tag word handshakes (m_adc_valid & m_adc_ready).
REQ-013 In DATA, the sample accepted when the in-packet counter equals latched length-1 carries m_adc_last=1; PKT_CNT increments on that sample's input acceptance.
REQ-014 After the last sample: -> TAG if enable=1, else -> IDLE.
REQ-015 Clearing enable mid-packet does not truncate: the current packet completes, then IDLE. Enabling in TAG is irrelevant since TAG always completes.
REQ-016 Latency: input sample to m_adc_valid is 1 cycle.

Reset
REQ-017 user_resetn low asynchronously forces: state IDLE; all registers, timestamp, PPS capture and PKT_CNT to 0; m_adc_valid, m_adc_tag_valid, m_adc_last, s_adc_ready, up_wack, up_rack to 0; m_adc_data, m_adc_tag_type, up_rdata to 0.
REQ-018 Reset mid-packet discards the partial packet with no last emitted; after release the block stays in IDLE until enable is written.

Verification
REQ-019 PKT_LEN=4, enable=1, s_valid=1 and m_ready=1 continuously -> repeating 5-word frames: tag data 0,4,8,...; last on the 4th sample of each frame; PKT_CNT=3 after 15 output words.
REQ-020 m_ready toggling 1/0 every cycle -> no word lost or duplicated; outputs stable while stalled; data sequence identical to REQ-019.
REQ-021 Enable cleared after the 2nd sample of a PKT_LEN=4 packet -> samples 3 and 4 still sent, last on sample 4; then IDLE and s_adc_ready=0.
REQ-022 PKT_LEN=0 -> every frame is tag plus one sample with last=1.
REQ-023 pps pulse after 10 accepted samples -> PPS_LO=10; clear write in the same cycle as a sample accept -> TIME_LO=0 next cycle.
REQ-024 user_resetn pulsed low mid-packet -> all outputs 0 immediately; read of 0x006 after re-enable returns 0; read of 0x1FF returns 0 with up_rack.

Source files
------------

// File: rtl/adc_tag_framer_if.sv
// Bundles the framer's register bus and its two sample streams.
// The slave view is the framer itself; the master view is whatever drives it.
interface adc_tag_framer_if;
   // register bus
   logic        up_wreq;
   logic [8:0]  up_waddr;
   logic [31:0] up_wdata;
   logic        up_wack;
   logic        up_rreq;
   logic [8:0]  up_raddr;
   logic [31:0] up_rdata;
   logic        up_rack;
   // incoming sample stream
   logic        s_adc_valid;
   logic [63:0] s_adc_data;
   logic        s_adc_ready;
   // outgoing framed stream
   logic        m_adc_ready;
   logic        m_adc_valid;
   logic [63:0] m_adc_data;
   logic        m_adc_tag_valid;
   logic [6:0]  m_adc_tag_type;
   logic        m_adc_last;

   modport master (
      output up_wreq, up_waddr, up_wdata,
      input  up_wack,
      output up_rreq, up_raddr,
      input  up_rdata, up_rack,
      output s_adc_valid, s_adc_data,
      input  s_adc_ready,
      output m_adc_ready,
      input  m_adc_valid, m_adc_data, m_adc_tag_valid, m_adc_tag_type, m_adc_last
   );

   modport slave (
      input  up_wreq, up_waddr, up_wdata,
      output up_wack,
      input  up_rreq, up_raddr,
      output up_rdata, up_rack,
      input  s_adc_valid, s_adc_data,
      output s_adc_ready,
      input  m_adc_ready,
      output m_adc_valid, m_adc_data, m_adc_tag_valid, m_adc_tag_type, m_adc_last
   );
endinterface

// File: rtl/adc_tag_framer.sv
// adc_tag_framer: splits an ADC sample stream into packets of PKT_LEN samples,
// each preceded by a timestamp tag word. The timestamp counts accepted samples,
// so a tag carries the sample index of the first sample that follows it.
module adc_tag_framer #(
   parameter logic [6:0]  TAG_TYPE_TIME = 7'h01,
   parameter int unsigned LEN_W         = 16
) (
   input  logic            user_clk,
   input  logic            user_resetn,
   input  logic            pps,
   adc_tag_framer_if.slave bus
);

   localparam logic [8:0]       ADDR_CTRL    = 9'h000;
   localparam logic [8:0]       ADDR_PKT_LEN = 9'h001;
   localparam logic [8:0]       ADDR_TIME_LO = 9'h002;
   localparam logic [8:0]       ADDR_TIME_HI = 9'h003;
   localparam logic [8:0]       ADDR_PPS_LO  = 9'h004;
   localparam logic [8:0]       ADDR_PPS_HI  = 9'h005;
   localparam logic [8:0]       ADDR_PKT_CNT = 9'h006;
   localparam logic [LEN_W-1:0] LEN_ZERO     = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TAG  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;

   logic             enable_r;
   logic [LEN_W-1:0] pkt_len_r;
   logic [LEN_W-1:0] len_lat_r;
   logic [LEN_W-1:0] cnt_r;
   logic [63:0]      ts_r;
   logic [63:0]      pps_ts_r;
   logic [31:0]      pkt_cnt_r;
   logic             pps_d_r;

   logic             wack_r;
   logic             rack_r;
   logic [31:0]      rdata_r;
   logic [31:0]      rdata_s;

   logic             m_valid_r;
   logic [63:0]      m_data_r;
   logic             m_tag_valid_r;
   logic [6:0]       m_tag_type_r;
   logic             m_last_r;

   logic             wr_ctrl_s;
   logic             wr_len_s;
   logic             clr_ts_s;
   logic             pps_rise_s;
   logic             out_free_s;
   logic             s_ready_s;
   logic             accept_s;
   logic             tag_load_s;
   logic             last_s;
   logic             enter_tag_s;
   logic             unused_wdata_s;

   // Only the low bits of the write data are architecturally meaningful.
   assign unused_wdata_s = ^bus.up_wdata;

   assign wr_ctrl_s  = bus.up_wreq & (bus.up_waddr == ADDR_CTRL);
   assign wr_len_s   = bus.up_wreq & (bus.up_waddr == ADDR_PKT_LEN);
   assign clr_ts_s   = wr_ctrl_s & bus.up_wdata[1];
   assign pps_rise_s = pps & ~pps_d_r;

   // The output register can take a new word when empty or draining this cycle.
   assign out_free_s  = ~m_valid_r | bus.m_adc_ready;
   assign s_ready_s   = (state_r == ST_DATA) & out_free_s;
   assign accept_s    = bus.s_adc_valid & s_ready_s;
   assign enter_tag_s = (state_r != ST_TAG) & (next_state_s == ST_TAG);

   // Packet sequencing: next state, tag load and end-of-packet detection.
   always_comb begin
      next_state_s = state_r;
      tag_load_s   = 1'b0;
      last_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable_r) begin
               next_state_s = ST_TAG;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_TAG: begin
            if (m_valid_r & m_tag_valid_r) begin
               // tag already presented: leave once it is taken downstream
               if (bus.m_adc_ready) begin
                  next_state_s = ST_DATA;
               end else begin
                  next_state_s = ST_TAG;
               end
            end else if (out_free_s) begin
               tag_load_s = 1'b1;
            end else begin
               tag_load_s = 1'b0;
            end
         end
         ST_DATA: begin
            if (accept_s && (cnt_r == (len_lat_r - LEN_ONE))) begin
               last_s = 1'b1;
               if (enable_r) begin
                  next_state_s = ST_TAG;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else begin
               next_state_s = ST_DATA;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Writable control registers; the clear-timestamp bit is a strobe, not stored.
   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         enable_r  <= 1'b0;
         pkt_len_r <= LEN_ZERO;
      end else begin
         if (wr_ctrl_s) begin
            enable_r <= bus.up_wdata[0];
         end
         if (wr_len_s) begin
            pkt_len_r <= bus.up_wdata[LEN_W-1:0];
         end
      end
   end

   // Sample timestamp; a clear request overrides a coincident increment.
   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         ts_r <= 64'h0;
      end else if (clr_ts_s) begin
         ts_r <= 64'h0;
      end else if (accept_s) begin
         ts_r <= ts_r + 64'd1;
      end
   end

   // Capture the timestamp on each pps rising edge.
   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         pps_d_r  <= 1'b0;
         pps_ts_r <= 64'h0;
      end else begin
         pps_d_r <= pps;
         if (pps_rise_s) begin
            pps_ts_r <= ts_r;
         end
      end
   end

   // Per-packet length snapshot, in-packet sample index and completed-packet count.
   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         len_lat_r <= LEN_ZERO;
         cnt_r     <= LEN_ZERO;
         pkt_cnt_r <= 32'h0;
      end else begin
         if (enter_tag_s) begin
            // a zero length would never terminate, so it behaves as one
            len_lat_r <= (pkt_len_r == LEN_ZERO) ? LEN_ONE : pkt_len_r;
            cnt_r     <= LEN_ZERO;
         end else if (accept_s) begin
            cnt_r <= last_s ? LEN_ZERO : (cnt_r + LEN_ONE);
         end
         if (last_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
         end
      end
   end

   // Output word register: sample, tag, drain, or hold while stalled.
   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         m_valid_r     <= 1'b0;
         m_data_r      <= 64'h0;
         m_tag_valid_r <= 1'b0;
         m_tag_type_r  <= 7'h00;
         m_last_r      <= 1'b0;
      end else if (accept_s) begin
         m_valid_r     <= 1'b1;
         m_data_r      <= bus.s_adc_data;
         m_tag_valid_r <= 1'b0;
         m_tag_type_r  <= 7'h00;
         m_last_r      <= last_s;
      end else if (tag_load_s) begin
         // the tag must match the timestamp the next sample will carry
         m_valid_r     <= 1'b1;
         m_data_r      <= clr_ts_s ? 64'h0 : ts_r;
         m_tag_valid_r <= 1'b1;
         m_tag_type_r  <= TAG_TYPE_TIME;
         m_last_r      <= 1'b0;
      end else if (bus.m_adc_ready) begin
         m_valid_r     <= 1'b0;
         m_data_r      <= 64'h0;
         m_tag_valid_r <= 1'b0;
         m_tag_type_r  <= 7'h00;
         m_last_r      <= 1'b0;
      end
   end

   // Register read decode; unmapped addresses read as zero.
   always_comb begin
      rdata_s = 32'h0;
      case (bus.up_raddr)
         ADDR_CTRL:    rdata_s = {31'h0, enable_r};
         ADDR_PKT_LEN: rdata_s = 32'(pkt_len_r);
         ADDR_TIME_LO: rdata_s = ts_r[31:0];
         ADDR_TIME_HI: rdata_s = ts_r[63:32];
         ADDR_PPS_LO:  rdata_s = pps_ts_r[31:0];
         ADDR_PPS_HI:  rdata_s = pps_ts_r[63:32];
         ADDR_PKT_CNT: rdata_s = pkt_cnt_r;
         default:      rdata_s = 32'h0;
      endcase
   end

   // Single-cycle bus acknowledges; read data is forced to zero when not acknowledged.
   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         wack_r  <= 1'b0;
         rack_r  <= 1'b0;
         rdata_r <= 32'h0;
      end else begin
         wack_r  <= bus.up_wreq;
         rack_r  <= bus.up_rreq;
         rdata_r <= bus.up_rreq ? rdata_s : 32'h0;
      end
   end

   assign bus.up_wack         = wack_r;
   assign bus.up_rack         = rack_r;
   assign bus.up_rdata        = rdata_r;
   assign bus.s_adc_ready     = s_ready_s;
   assign bus.m_adc_valid     = m_valid_r;
   assign bus.m_adc_data      = m_data_r;
   assign bus.m_adc_tag_valid = m_tag_valid_r;
   assign bus.m_adc_tag_type  = m_tag_type_r;
   assign bus.m_adc_last      = m_last_r;

endmodule

// File: tb/tb_adc_tag_framer.sv
// Self-checking bench for adc_tag_framer: randomized stream traffic checked
// against a frame-level model (tag every L samples, tag = sample index).
module tb_adc_tag_framer;
   localparam logic [6:0] TAG_T = 7'h01;

   logic user_clk = 1'b0;
   logic user_resetn;
   logic pps;
   adc_tag_framer_if bus ();

   adc_tag_framer #(.TAG_TYPE_TIME(TAG_T), .LEN_W(16)) dut (
      .user_clk   (user_clk),
      .user_resetn(user_resetn),
      .pps        (pps),
      .bus        (bus)
   );

   always #5 user_clk = ~user_clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] data_arr [0:255];
   logic [63:0] out_data [0:511];
   logic        out_tag  [0:511];
   logic        out_last [0:511];
   int          acc_cnt = 0;
   int          out_cnt = 0;
   int          max_acc = 0;
   int          cur_l = 1;
   int          vmode = 0;
   int          rmode = 0;
   bit          model_on = 1'b0;

   task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected word number idx of a phase: frames of one tag plus cur_l samples.
   function automatic void exp_word(input int idx, output logic t, output logic [63:0] d, output logic l);
      int fr;
      int pos;
      fr  = idx / (cur_l + 1);
      pos = idx % (cur_l + 1);
      if (pos == 0) begin
         t = 1'b1; d = 64'(fr * cur_l); l = 1'b0;
      end else begin
         t = 1'b0; d = data_arr[(fr * cur_l + pos - 1) % 256]; l = (pos == cur_l);
      end
   endfunction

   // Compare process: counts handshakes, checks output words and stall stability.
   initial begin : compare
      logic        stall_p;
      logic [73:0] snap;
      logic [73:0] cur;
      logic        et, el;
      logic [63:0] ed;
      stall_p = 1'b0;
      snap    = '0;
      forever begin
         @(negedge user_clk);
         if (user_resetn !== 1'b1) begin
            stall_p = 1'b0;
         end else begin
            cur = {bus.m_adc_valid, bus.m_adc_tag_valid, bus.m_adc_tag_type, bus.m_adc_last, bus.m_adc_data};
            if (stall_p) check("stall_hold", 80'(cur), 80'(snap));
            if (!bus.up_rack) check("rdata_idle", 80'(bus.up_rdata), 80'd0);
            if (bus.s_adc_valid && bus.s_adc_ready) acc_cnt++;
            if (bus.m_adc_valid && bus.m_adc_ready) begin
               if (out_cnt < 512) begin
                  out_data[out_cnt] = bus.m_adc_data;
                  out_tag[out_cnt]  = bus.m_adc_tag_valid;
                  out_last[out_cnt] = bus.m_adc_last;
               end
               if (model_on) begin
                  exp_word(out_cnt, et, ed, el);
                  check("out_word", 80'({bus.m_adc_tag_valid, bus.m_adc_last, bus.m_adc_data}), 80'({et, el, ed}));
                  if (et) check("tag_type", 80'(bus.m_adc_tag_type), 80'(TAG_T));
               end
               out_cnt++;
            end
            stall_p = bus.m_adc_valid & ~bus.m_adc_ready;
            snap    = cur;
         end
      end
   end

   // Stream driver: sample k is presented until accepted; ready per mode.
   initial begin
      bus.s_adc_valid = 1'b0;
      bus.s_adc_data  = 64'h0;
      bus.m_adc_ready = 1'b0;
      forever begin
         @(posedge user_clk); #1;
         bus.s_adc_valid = (acc_cnt < max_acc) && (vmode == 0 || $urandom_range(0, 1) == 1);
         bus.s_adc_data  = data_arr[acc_cnt % 256];
         case (rmode)
            0:       bus.m_adc_ready = 1'b1;
            1:       bus.m_adc_ready = ~bus.m_adc_ready;
            default: bus.m_adc_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Bus tasks are entered and left just after a rising edge.
   task automatic reg_write(input logic [8:0] a, input logic [31:0] d);
      bus.up_wreq = 1'b1; bus.up_waddr = a; bus.up_wdata = d;
      @(posedge user_clk); #1;
      bus.up_wreq = 1'b0;
      check("wack", 80'(bus.up_wack), 80'd1);
   endtask

   task automatic reg_read(input logic [8:0] a, input logic [31:0] exp, input string name);
      bus.up_rreq = 1'b1; bus.up_raddr = a;
      @(posedge user_clk); #1;
      bus.up_rreq = 1'b0;
      check({name, "_rack"}, 80'(bus.up_rack), 80'd1);
      check(name, 80'(bus.up_rdata), 80'(exp));
   endtask

   task automatic wait_out(input int n, input int budget);
      int c;
      c = 0;
      while (out_cnt < n && c < budget) begin
         @(posedge user_clk); #1; c++;
      end
      check("wait_out_reached", 80'(out_cnt >= n), 80'd1);
   endtask

   task automatic wait_acc(input int n, input int budget);
      int c;
      c = 0;
      while (acc_cnt < n && c < budget) begin
         @(posedge user_clk); #1; c++;
      end
      check("wait_acc_reached", 80'(acc_cnt >= n), 80'd1);
   endtask

   task automatic do_reset();
      model_on = 1'b0;
      max_acc  = 0;
      user_resetn = 1'b0;
      repeat (2) @(posedge user_clk);
      #1;
      acc_cnt = 0;
      out_cnt = 0;
      user_resetn = 1'b1;
   endtask

   task automatic start_phase(input int len, input int nacc, input int vm, input int rm, input bit seq_data);
      do_reset();
      for (int k = 0; k < 256; k++) data_arr[k] = seq_data ? 64'(k) : {$urandom, $urandom};
      cur_l = (len == 0) ? 1 : len;
      vmode = vm;
      rmode = rm;
      reg_write(9'h001, 32'(len));
      model_on = 1'b1;
      max_acc  = nacc;
      reg_write(9'h000, 32'h1);
   endtask

   initial begin
      int len, l, np, rem, exp_out;
      user_resetn = 1'b0;
      pps = 1'b0;
      bus.up_wreq = 1'b0; bus.up_waddr = 9'h0; bus.up_wdata = 32'h0;
      bus.up_rreq = 1'b0; bus.up_raddr = 9'h0;
      for (int k = 0; k < 256; k++) data_arr[k] = 64'(k);

      // reset state
      repeat (3) @(posedge user_clk);
      #1;
      check("rst_stream", 80'({bus.m_adc_valid, bus.m_adc_tag_valid, bus.m_adc_last, bus.s_adc_ready}), 80'd0);
      check("rst_data", 80'({bus.m_adc_data, bus.m_adc_tag_type}), 80'd0);
      check("rst_bus", 80'({bus.up_wack, bus.up_rack, bus.up_rdata}), 80'd0);

      // continuous flow, PKT_LEN=4, sequential data
      start_phase(4, 12, 0, 0, 1'b1);
      wait_out(16, 300);
      repeat (10) @(posedge user_clk);
      #1;
      check("A_out_count", 80'(out_cnt), 80'd16);
      check("A_word0", 80'({out_tag[0], out_data[0]}), 80'({1'b1, 64'd0}));
      check("A_word4", 80'({out_last[4], out_data[4]}), 80'({1'b1, 64'd3}));
      check("A_word5", 80'({out_tag[5], out_data[5]}), 80'({1'b1, 64'd4}));
      check("A_word10", 80'({out_tag[10], out_data[10]}), 80'({1'b1, 64'd8}));
      reg_read(9'h006, 32'd3, "A_pkt_cnt");
      reg_read(9'h002, 32'd12, "A_time_lo");

      // downstream ready toggling every cycle
      start_phase(4, 12, 0, 1, 1'b1);
      wait_out(16, 400);
      repeat (10) @(posedge user_clk);
      #1;
      check("B_out_count", 80'(out_cnt), 80'd16);
      check("B_word10", 80'({out_tag[10], out_data[10]}), 80'({1'b1, 64'd8}));
      check("B_word14", 80'({out_last[14], out_data[14]}), 80'({1'b1, 64'd11}));

      // enable cleared after the second sample
      start_phase(4, 200, 0, 0, 1'b0);
      wait_acc(2, 100);
      reg_write(9'h000, 32'h0);
      repeat (20) @(posedge user_clk);
      #1;
      check("C_acc_count", 80'(acc_cnt), 80'd4);
      check("C_out_count", 80'(out_cnt), 80'd5);
      check("C_last", 80'(out_last[4]), 80'd1);
      check("C_idle", 80'({bus.s_adc_ready, bus.m_adc_valid}), 80'd0);
      reg_read(9'h006, 32'd1, "C_pkt_cnt");

      // PKT_LEN=0 behaves as one
      start_phase(0, 20, 1, 2, 1'b0);
      wait_out(41, 2000);
      repeat (10) @(posedge user_clk);
      #1;
      check("D_out_count", 80'(out_cnt), 80'd41);
      check("D_word1", 80'({out_tag[1], out_last[1]}), 80'({1'b0, 1'b1}));
      check("D_word2", 80'(out_tag[2]), 80'd1);
      reg_read(9'h006, 32'd20, "D_pkt_cnt");

      // random lengths with random valid/ready
      for (int it = 0; it < 3; it++) begin
         len = $urandom_range(0, 7);
         l = (len == 0) ? 1 : len;
         np = 60 / l;
         rem = 60 % l;
         exp_out = np * (l + 1) + 1 + rem;
         start_phase(len, 60, 1, 2, 1'b0);
         wait_out(exp_out, 4000);
         repeat (10) @(posedge user_clk);
         #1;
         check("E_out_count", 80'(out_cnt), 80'(exp_out));
         reg_read(9'h006, 32'(np), "E_pkt_cnt");
         reg_read(9'h002, 32'd60, "E_time_lo");
      end

      // pps capture and timestamp clear
      start_phase(4, 10, 0, 0, 1'b0);
      wait_acc(10, 200);
      repeat (3) @(posedge user_clk);
      #1;
      pps = 1'b1;
      @(posedge user_clk); #1;
      pps = 1'b0;
      repeat (2) @(posedge user_clk);
      #1;
      reg_read(9'h004, 32'd10, "F_pps_lo");
      reg_read(9'h005, 32'd0, "F_pps_hi");
      model_on = 1'b0;
      max_acc  = 200;
      repeat (3) @(posedge user_clk);
      #1;
      reg_write(9'h000, 32'h3);
      reg_read(9'h002, 32'd0, "F_time_clr");

      // asynchronous reset mid-packet
      repeat (2) @(posedge user_clk);
      #1;
      user_resetn = 1'b0;
      #1;
      check("G_rst_stream", 80'({bus.m_adc_valid, bus.m_adc_tag_valid, bus.m_adc_last, bus.s_adc_ready}), 80'd0);
      check("G_rst_data", 80'({bus.m_adc_data, bus.m_adc_tag_type}), 80'd0);
      check("G_rst_bus", 80'({bus.up_wack, bus.up_rack, bus.up_rdata}), 80'd0);
      repeat (2) @(posedge user_clk);
      #1;
      acc_cnt = 0;
      out_cnt = 0;
      user_resetn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge user_clk); #1;
         check("G_stay_idle", 80'({bus.s_adc_ready, bus.m_adc_valid}), 80'd0);
      end
      max_acc = 0;
      reg_write(9'h000, 32'h1);
      reg_read(9'h006, 32'd0, "G_pkt_cnt");
      check("G_wack_pulse", 80'(bus.up_wack), 80'd0);
      reg_read(9'h1FF, 32'd0, "G_unmapped");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
